home_automation_ctrl: RTL and testbench
=======================================

HOME_AUTOMATION_CTRL -- requirements
Module: home_automation_ctrl

Interface
REQ-001 The block SHALL have parameter TEMP_W, default 8, meaning temperature/setpoint width in bits, unsigned.
REQ-002 The block SHALL have parameter N_WIN, default 4, meaning the number of window contacts.
REQ-003 The block SHALL have parameter N_DOOR, default 2, meaning the number of door contacts.
REQ-004 The block SHALL have parameter CNT_W, default 4, meaning the person counter width.
REQ-005 The block SHALL have parameter MIN_OFF, default 16, meaning AC rest cycles after any stop, at least 1.
REQ-006 The block SHALL have parameter OPEN_DLY, default 8, meaning consecutive open cycles before eco shutoff, at least 1.
REQ-007 The block SHALL have parameter ARM_DLY, default 32, meaning consecutive empty-house cycles before arming, at least 1.
REQ-008 The block SHALL have the following ports, one per line, as name, direction, width, meaning:
- clk_i  in  1  single clock, all logic on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- cfg_we_i  in  1  config write strobe
- cfg_addr_i  in  2  config register select
- cfg_wdata_i  in  TEMP_W  config write data
- temperature_i  in  TEMP_W  measured temperature
- window_status_i  in  N_WIN  1 = window open
- door_status_i  in  N_DOOR  1 = door open
- person_in_i  in  1  one-cycle entry pulse
- person_out_i  in  1  one-cycle exit pulse
- ac_heat_o  out  1  heater on
- ac_cool_o  out  1  cooler on
- lock_doors_o  out  1  lock doors
- lock_windows_o  out  1  lock windows
- person_count_o  out  CNT_W  occupants
- alarm_o  out  1  sticky intrusion flag

Function
REQ-009 Config registers SHALL be written on cfg_we_i, effective next cycle: addr0 setpoint; addr1 [1:0] mode (0 off, 1 heat, 2 cool, 3 auto); addr2 bit0 eco_en, bit1 sec_en; addr3 hysteresis.
REQ-010 Thresholds SHALL be lo = setpoint-hyst, saturating at 0, and hi = setpoint+hyst, saturating at 2^TEMP_W-1.
REQ-011 The AC FSM SHALL have states OFF, HEAT, COOL, REST; outputs are registered, ac_heat_o = (state==HEAT), ac_cool_o = (state==COOL), never both high.
REQ-012 OFF->HEAT SHALL occur when mode is 1 or 3, temperature_i < lo, and no eco_block; OFF->COOL when mode is 2 or 3, temperature_i > hi, and no eco_block; heat takes priority if both hold.
REQ-013 HEAT->REST SHALL occur when temperature_i >= setpoint, mode disallows heat, or eco_block; COOL->REST symmetrically with temperature_i <= setpoint.
REQ-014 REST SHALL last exactly MIN_OFF cycles, then go to OFF; no direct HEAT<->COOL transition.
REQ-015 open_cnt SHALL increment, saturating at OPEN_DLY, each cycle any window or door is open, and clear in the cycle all are closed; eco_block = eco_en && open_cnt==OPEN_DLY.
REQ-016 The person counter SHALL do +1 on in-only, -1 on out-only, hold on both or neither, saturate at 2^CNT_W-1, and never go below 0.
REQ-017 empty_cnt SHALL count cycles with sec_en && count==0, saturating at ARM_DLY; armed = (empty_cnt==ARM_DLY); any other cycle clears empty_cnt, disarming next edge.
REQ-018 lock_doors_o and lock_windows_o SHALL equal armed.
REQ-019 alarm_o SHALL set when armed and any opening is open; it SHALL hold until sec_en is written 0.
REQ-020 Simultaneous config write and FSM decision SHALL use the old register values.

Reset
REQ-021 On rst_n_i low, all outputs, counters and FSM SHALL go to 0/OFF immediately; setpoint = 2^(TEMP_W-1), mode = 0, eco_en = sec_en = 0, hyst = 2; reset mid-HEAT/REST SHALL abandon the rest period.

Structure
REQ-022 Mode encodings, config addresses and FSM state enum SHALL live in shared package home_automation_pkg.
REQ-023 The AC FSM SHALL be sub-module ac_hvac_fsm; the remaining logic SHALL be inline.

Verification
REQ-024 Scenario: setpoint 20, hyst 2, mode 3, temperature 17 -> ac_heat_o = 1 one cycle after; temperature 20 -> heat 0, then 16 cycles with no output.
REQ-025 Scenario: mode 2, temperature 25 -> cool; eco_en = 1, window[0] open 8 cycles -> ac_cool_o drops on cycle 9; close the window after REST -> cool resumes.
REQ-026 Scenario: 15 entries, then 3 more -> count stays 15; simultaneous in/out -> unchanged; exits at 0 -> count stays 0.
REQ-027 Scenario: sec_en = 1, count 0 -> locks rise after 32 cycles; one entry pulse -> locks fall the following cycle.
REQ-028 Scenario: armed, door[1] opens -> alarm_o = 1 and stays 1 after the door closes; write sec_en = 0 -> alarm_o = 0.
REQ-029 Scenario: reset asserted mid-COOL -> all outputs 0 asynchronously; after release, FSM is OFF.

Source files
------------

// File: rtl/home_automation_pkg.sv
// Shared definitions for the home automation controller.
// Holds mode encodings, config register addresses and the AC FSM state enum.
// Imported by home_automation_ctrl and ac_hvac_fsm.
package home_automation_pkg;

    // Config register addresses
    localparam logic [1:0] ADDR_SETPOINT = 2'd0;
    localparam logic [1:0] ADDR_MODE     = 2'd1;
    localparam logic [1:0] ADDR_CTRL     = 2'd2;  // bit0 eco_en, bit1 sec_en
    localparam logic [1:0] ADDR_HYST     = 2'd3;

    // AC operating modes
    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_HEAT = 2'd1;
    localparam logic [1:0] MODE_COOL = 2'd2;
    localparam logic [1:0] MODE_AUTO = 2'd3;

    typedef enum logic [1:0] {
        AC_OFF  = 2'd0,
        AC_HEAT = 2'd1,
        AC_COOL = 2'd2,
        AC_REST = 2'd3
    } ac_state_t;

    function automatic logic mode_allows_heat(input logic [1:0] mode);
        return (mode == MODE_HEAT) || (mode == MODE_AUTO);
    endfunction

    function automatic logic mode_allows_cool(input logic [1:0] mode);
        return (mode == MODE_COOL) || (mode == MODE_AUTO);
    endfunction

endpackage

// File: rtl/ac_hvac_fsm.sv
// Purpose: heat/cool controller with hysteresis and a mandatory rest period after any stop.
// Latency: outputs are registered, one cycle after the deciding inputs.
// Backpressure: none; inputs are sampled every cycle.
// Ports: clk_i/rst_n_i clock and async active-low reset; i_temp measured temperature;
//        i_setpoint/i_lo/i_hi thresholds; i_mode AC mode; i_eco_block opening shutoff;
//        o_heat/o_cool registered actuator enables (mutually exclusive).
module ac_hvac_fsm
    import home_automation_pkg::*;
#(
    parameter int TEMP_W  = 8,
    parameter int MIN_OFF = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [TEMP_W-1:0] i_temp,
    input  logic [TEMP_W-1:0] i_setpoint,
    input  logic [TEMP_W-1:0] i_lo,
    input  logic [TEMP_W-1:0] i_hi,
    input  logic [1:0]        i_mode,
    input  logic              i_eco_block,
    output logic              o_heat,
    output logic              o_cool
);

    localparam int RW = $clog2(MIN_OFF + 1);

    ac_state_t         r_state;
    ac_state_t         w_state_nxt;
    logic [RW-1:0]     r_rest_cnt;
    logic [RW-1:0]     w_rest_nxt;
    logic              r_heat;
    logic              r_cool;
    logic              w_heat_ok;
    logic              w_cool_ok;

    assign w_heat_ok = mode_allows_heat(i_mode);
    assign w_cool_ok = mode_allows_cool(i_mode);

    always_comb begin
        w_state_nxt = r_state;
        w_rest_nxt  = r_rest_cnt;
        case (r_state)
            AC_OFF: begin
                // Heat wins if both demands hold (only possible with odd thresholds).
                if (w_heat_ok && (i_temp < i_lo) && !i_eco_block)
                    w_state_nxt = AC_HEAT;
                else if (w_cool_ok && (i_temp > i_hi) && !i_eco_block)
                    w_state_nxt = AC_COOL;
            end
            AC_HEAT: begin
                if ((i_temp >= i_setpoint) || !w_heat_ok || i_eco_block) begin
                    w_state_nxt = AC_REST;
                    w_rest_nxt  = RW'(MIN_OFF - 1);
                end
            end
            AC_COOL: begin
                if ((i_temp <= i_setpoint) || !w_cool_ok || i_eco_block) begin
                    w_state_nxt = AC_REST;
                    w_rest_nxt  = RW'(MIN_OFF - 1);
                end
            end
            AC_REST: begin
                // Counter loaded with MIN_OFF-1 on entry, so REST spans MIN_OFF cycles.
                if (r_rest_cnt == '0)
                    w_state_nxt = AC_OFF;
                else
                    w_rest_nxt = r_rest_cnt - RW'(1);
            end
            default: w_state_nxt = AC_OFF;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= AC_OFF;
            r_rest_cnt <= '0;
            r_heat     <= 1'b0;
            r_cool     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rest_cnt <= w_rest_nxt;
            r_heat     <= (w_state_nxt == AC_HEAT);
            r_cool     <= (w_state_nxt == AC_COOL);
        end
    end

    assign o_heat = r_heat;
    assign o_cool = r_cool;

endmodule

// File: rtl/home_automation_ctrl.sv
// Purpose: home controller - config regs, AC FSM, opening eco shutoff, occupancy, security arming/alarm.
// Latency: config effective next cycle; AC/alarm outputs one cycle after inputs; locks follow armed count.
// Backpressure: none; every input is sampled each cycle.
// Ports: clk_i/rst_n_i clock and async active-low reset; cfg_* register write port;
//        temperature_i, window_status_i, door_status_i sensors; person_in_i/person_out_i pulses;
//        ac_heat_o/ac_cool_o, lock_doors_o/lock_windows_o, person_count_o, alarm_o.
module home_automation_ctrl
    import home_automation_pkg::*;
#(
    parameter int TEMP_W   = 8,
    parameter int N_WIN    = 4,
    parameter int N_DOOR   = 2,
    parameter int CNT_W    = 4,
    parameter int MIN_OFF  = 16,
    parameter int OPEN_DLY = 8,
    parameter int ARM_DLY  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cfg_we_i,
    input  logic [1:0]        cfg_addr_i,
    input  logic [TEMP_W-1:0] cfg_wdata_i,
    input  logic [TEMP_W-1:0] temperature_i,
    input  logic [N_WIN-1:0]  window_status_i,
    input  logic [N_DOOR-1:0] door_status_i,
    input  logic              person_in_i,
    input  logic              person_out_i,
    output logic              ac_heat_o,
    output logic              ac_cool_o,
    output logic              lock_doors_o,
    output logic              lock_windows_o,
    output logic [CNT_W-1:0]  person_count_o,
    output logic              alarm_o
);

    localparam int OW = $clog2(OPEN_DLY + 1);
    localparam int EW = $clog2(ARM_DLY + 1);

    logic [TEMP_W-1:0] r_setpoint;
    logic [1:0]        r_mode;
    logic              r_eco_en;
    logic              r_sec_en;
    logic [TEMP_W-1:0] r_hyst;
    logic [OW-1:0]     r_open_cnt;
    logic [EW-1:0]     r_empty_cnt;
    logic [CNT_W-1:0]  r_count;
    logic              r_alarm;

    logic [TEMP_W:0]   w_hi_ext;
    logic [TEMP_W-1:0] w_hi;
    logic [TEMP_W-1:0] w_lo;
    logic              w_any_open;
    logic              w_eco_block;
    logic              w_armed;
    logic              w_sec_clr;

    // Config registers; reset setpoint is mid-scale.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_setpoint <= {1'b1, {(TEMP_W-1){1'b0}}};
            r_mode     <= MODE_OFF;
            r_eco_en   <= 1'b0;
            r_sec_en   <= 1'b0;
            r_hyst     <= TEMP_W'(2);
        end else if (cfg_we_i) begin
            case (cfg_addr_i)
                ADDR_SETPOINT: r_setpoint <= cfg_wdata_i;
                ADDR_MODE:     r_mode     <= cfg_wdata_i[1:0];
                ADDR_CTRL: begin
                    r_eco_en <= cfg_wdata_i[0];
                    r_sec_en <= cfg_wdata_i[1];
                end
                default:       r_hyst     <= cfg_wdata_i;
            endcase
        end
    end

    // Saturating thresholds: hi uses one extra bit to detect overflow.
    assign w_hi_ext = {1'b0, r_setpoint} + {1'b0, r_hyst};
    assign w_hi     = w_hi_ext[TEMP_W] ? '1 : w_hi_ext[TEMP_W-1:0];
    assign w_lo     = (r_setpoint > r_hyst) ? (r_setpoint - r_hyst) : '0;

    assign w_any_open  = (|window_status_i) || (|door_status_i);
    assign w_eco_block = r_eco_en && (r_open_cnt == OW'(OPEN_DLY));
    assign w_armed     = (r_empty_cnt == EW'(ARM_DLY));
    assign w_sec_clr   = cfg_we_i && (cfg_addr_i == ADDR_CTRL) && !cfg_wdata_i[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_open_cnt <= '0;
        end else if (!w_any_open) begin
            r_open_cnt <= '0;
        end else if (r_open_cnt != OW'(OPEN_DLY)) begin
            r_open_cnt <= r_open_cnt + OW'(1);
        end
    end

    // Occupancy: simultaneous in/out cancels; saturate at both ends.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (person_in_i && !person_out_i && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end else if (!person_in_i && person_out_i && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_empty_cnt <= '0;
        end else if (!(r_sec_en && (r_count == '0))) begin
            r_empty_cnt <= '0;
        end else if (!w_armed) begin
            r_empty_cnt <= r_empty_cnt + EW'(1);
        end
    end

    // Alarm is sticky; only a write clearing sec_en releases it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_alarm <= 1'b0;
        end else if (w_sec_clr) begin
            r_alarm <= 1'b0;
        end else if (w_armed && w_any_open) begin
            r_alarm <= 1'b1;
        end
    end

    ac_hvac_fsm #(
        .TEMP_W  (TEMP_W),
        .MIN_OFF (MIN_OFF)
    ) u_ac_hvac_fsm (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_temp      (temperature_i),
        .i_setpoint  (r_setpoint),
        .i_lo        (w_lo),
        .i_hi        (w_hi),
        .i_mode      (r_mode),
        .i_eco_block (w_eco_block),
        .o_heat      (ac_heat_o),
        .o_cool      (ac_cool_o)
    );

    assign lock_doors_o   = w_armed;
    assign lock_windows_o = w_armed;
    assign person_count_o = r_count;
    assign alarm_o        = r_alarm;

endmodule

// File: tb/tb_home_automation_ctrl.sv
// Purpose: directed self-checking bench for home_automation_ctrl (default parameters).
// Latency: inputs driven after the falling edge, outputs sampled at the next falling edge.
// Backpressure: n/a.
module tb_home_automation_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       cfg_we_i;
    logic [1:0] cfg_addr_i;
    logic [7:0] cfg_wdata_i;
    logic [7:0] temperature_i;
    logic [3:0] window_status_i;
    logic [1:0] door_status_i;
    logic       person_in_i;
    logic       person_out_i;
    logic       ac_heat_o;
    logic       ac_cool_o;
    logic       lock_doors_o;
    logic       lock_windows_o;
    logic [3:0] person_count_o;
    logic       alarm_o;

    int n_tests = 0;
    int n_fail  = 0;

    home_automation_ctrl dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .cfg_we_i        (cfg_we_i),
        .cfg_addr_i      (cfg_addr_i),
        .cfg_wdata_i     (cfg_wdata_i),
        .temperature_i   (temperature_i),
        .window_status_i (window_status_i),
        .door_status_i   (door_status_i),
        .person_in_i     (person_in_i),
        .person_out_i    (person_out_i),
        .ac_heat_o       (ac_heat_o),
        .ac_cool_o       (ac_cool_o),
        .lock_doors_o    (lock_doors_o),
        .lock_windows_o  (lock_windows_o),
        .person_count_o  (person_count_o),
        .alarm_o         (alarm_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic cfg_wr(input logic [1:0] addr, input logic [7:0] data);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        @(negedge clk_i);
        cfg_we_i    = 1'b0;
    endtask

    task automatic pulse(input logic pin, input logic pout);
        person_in_i  = pin;
        person_out_i = pout;
        @(negedge clk_i);
        person_in_i  = 1'b0;
        person_out_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_heat"},  ac_heat_o,      0);
        chk({tag, "_cool"},  ac_cool_o,      0);
        chk({tag, "_lockd"}, lock_doors_o,   0);
        chk({tag, "_lockw"}, lock_windows_o, 0);
        chk({tag, "_count"}, person_count_o, 0);
        chk({tag, "_alarm"}, alarm_o,        0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n_i         = 1'b0;
        cfg_we_i        = 1'b0;
        cfg_addr_i      = 2'd0;
        cfg_wdata_i     = 8'd0;
        temperature_i   = 8'd0;
        window_status_i = 4'd0;
        door_status_i   = 2'd0;
        person_in_i     = 1'b0;
        person_out_i    = 1'b0;

        #2;
        chk_all_zero("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // lo saturates at 0: setpoint 1, hyst 2, temp 0 -> no heat
        cfg_wr(2'd0, 8'd1);
        cfg_wr(2'd3, 8'd2);
        cfg_wr(2'd1, 8'd3);
        tick(2);
        chk("lo_sat_heat", ac_heat_o, 0);
        chk("lo_sat_cool", ac_cool_o, 0);
        cfg_wr(2'd1, 8'd0);

        // hi saturates at 255: setpoint 254, hyst 5, temp 255 -> no cool
        temperature_i = 8'd255;
        cfg_wr(2'd0, 8'd254);
        cfg_wr(2'd3, 8'd5);
        cfg_wr(2'd1, 8'd3);
        tick(2);
        chk("hi_sat_cool", ac_cool_o, 0);
        chk("hi_sat_heat", ac_heat_o, 0);
        cfg_wr(2'd1, 8'd0);

        // Heating: setpoint 20, hyst 2 -> lo 18, hi 22
        temperature_i = 8'd20;
        cfg_wr(2'd0, 8'd20);
        cfg_wr(2'd3, 8'd2);
        cfg_wr(2'd1, 8'd3);
        temperature_i = 8'd17;
        tick(1);
        chk("heat_on", ac_heat_o, 1);
        chk("heat_on_cool", ac_cool_o, 0);
        temperature_i = 8'd20;
        tick(1);
        chk("heat_stop", ac_heat_o, 0);
        // Demand returns at once, but REST (16 cycles) then one OFF cycle precede HEAT.
        temperature_i = 8'd17;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            chk($sformatf("rest_%0d", i), ac_heat_o, 0);
        end
        tick(1);
        chk("heat_after_rest", ac_heat_o, 1);

        // Config write and FSM decision in the same cycle: old mode still applies.
        cfg_wr(2'd1, 8'd0);
        chk("old_mode_heat", ac_heat_o, 1);
        tick(1);
        chk("new_mode_off", ac_heat_o, 0);

        // Cooling
        temperature_i = 8'd25;
        tick(16);
        cfg_wr(2'd1, 8'd2);
        chk("cool_old_mode", ac_cool_o, 0);
        tick(1);
        chk("cool_on", ac_cool_o, 1);

        // Eco shutoff on an open window
        cfg_wr(2'd2, 8'd1);
        chk("eco_en_cool", ac_cool_o, 1);
        window_status_i = 4'b0001;
        tick(8);
        chk("eco_open8", ac_cool_o, 1);
        tick(1);
        chk("eco_open9", ac_cool_o, 0);
        tick(20);
        chk("eco_blocked", ac_cool_o, 0);
        window_status_i = 4'b0000;
        tick(1);
        chk("eco_close1", ac_cool_o, 0);
        tick(1);
        chk("eco_resume", ac_cool_o, 1);

        // Occupancy counter
        pulse(1'b1, 1'b0);
        chk("cnt_1", person_count_o, 1);
        for (int i = 0; i < 14; i++) pulse(1'b1, 1'b0);
        chk("cnt_15", person_count_o, 15);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        chk("cnt_sat", person_count_o, 15);
        pulse(1'b1, 1'b1);
        chk("cnt_both", person_count_o, 15);
        pulse(1'b0, 1'b1);
        chk("cnt_14", person_count_o, 14);
        for (int i = 0; i < 14; i++) pulse(1'b0, 1'b1);
        chk("cnt_0", person_count_o, 0);
        for (int i = 0; i < 2; i++) pulse(1'b0, 1'b1);
        chk("cnt_floor", person_count_o, 0);

        // Arming: sec_en=1 (eco off), empty house
        cfg_wr(2'd2, 8'd2);
        tick(31);
        chk("arm_31_lockd", lock_doors_o, 0);
        chk("arm_31_lockw", lock_windows_o, 0);
        tick(1);
        chk("arm_32_lockd", lock_doors_o, 1);
        chk("arm_32_lockw", lock_windows_o, 1);
        pulse(1'b1, 1'b0);
        chk("entry_cnt", person_count_o, 1);
        chk("entry_lock_hold", lock_doors_o, 1);
        tick(1);
        chk("entry_unlock_d", lock_doors_o, 0);
        chk("entry_unlock_w", lock_windows_o, 0);
        pulse(1'b0, 1'b1);
        tick(31);
        chk("rearm_31", lock_doors_o, 0);
        tick(1);
        chk("rearm_32", lock_doors_o, 1);

        // Intrusion alarm
        chk("alarm_idle", alarm_o, 0);
        door_status_i = 2'b10;
        tick(1);
        chk("alarm_set", alarm_o, 1);
        door_status_i = 2'b00;
        tick(3);
        chk("alarm_sticky", alarm_o, 1);
        cfg_wr(2'd2, 8'd0);
        chk("alarm_clr", alarm_o, 0);

        // Asynchronous reset mid-COOL
        chk("pre_rst_cool", ac_cool_o, 1);
        pulse(1'b1, 1'b0);
        chk("pre_rst_cnt", person_count_o, 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick(2);
        chk("post_rst_cool", ac_cool_o, 0);
        chk("post_rst_heat", ac_heat_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
